// File: rtl/mult_acc128.sv
// mult_acc128: sums LEN consecutive 128-bit products into an AW-bit accumulator.
// Optional macro ACC_SAT_EN: clamp the accumulator to all ones on carry instead of wrapping.
module mult_acc128 #(
   parameter int PW  = 128,
   parameter int AW  = 136,
   parameter int LEN = 4,
   parameter int CW  = $clog2(LEN) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] prod,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] acc_out,
   output logic          ovf,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic [AW:0]   sum;

   // Extra top bit of the sum is the carry out of the accumulator.
   assign sum = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, prod};

   // Handshake flags decode straight from the state register.
   assign in_ready  = (state_q == ACC);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign acc_out   = acc_q;
   assign ovf       = ovf_q;

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = ACC;
            end
         end
         ACC: begin
            if (in_valid) begin
               cnt_d = cnt_q + CW'(1);
               ovf_d = ovf_q | sum[AW];
`ifdef ACC_SAT_EN
               // Once clamped, any further add carries again, so it stays clamped.
               acc_d = sum[AW] ? '1 : sum[AW-1:0];
`else
               acc_d = sum[AW-1:0];
`endif
               if (cnt_q == CW'(LEN - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               if (start) begin
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = ACC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_mult_acc128.sv
// tb_mult_acc128: directed vectors for mult_acc128.
// Instance a uses default widths; instance b uses AW=129 to reach overflow.
module tb_mult_acc128;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         in_valid;
   logic [127:0] prod;
   logic         out_ready;

   logic         in_ready_a, out_valid_a, ovf_a, busy_a;
   logic [135:0] acc_out_a;
   logic         in_ready_b, out_valid_b, ovf_b, busy_b;
   logic [128:0] acc_out_b;

   int n_vec;
   int n_err;

   logic [135:0] wrap_b;
   logic [135:0] sat_b;
   logic [135:0] exp_b;

   mult_acc128 u_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a),
      .prod      (prod),
      .out_valid (out_valid_a),
      .out_ready (out_ready),
      .acc_out   (acc_out_a),
      .ovf       (ovf_a),
      .busy      (busy_a)
   );

   mult_acc128 #(.AW(129)) u_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready_b),
      .prod      (prod),
      .out_valid (out_valid_b),
      .out_ready (out_ready),
      .acc_out   (acc_out_b),
      .ovf       (ovf_b),
      .busy      (busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [135:0] obs,
                      input logic [135:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic chk_flags(input string tag, input logic iv, input logic ov,
                            input logic bz);
      chk({tag, "_in_ready"}, {135'b0, in_ready_a}, {135'b0, iv});
      chk({tag, "_out_valid"}, {135'b0, out_valid_a}, {135'b0, ov});
      chk({tag, "_busy"}, {135'b0, busy_a}, {135'b0, bz});
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      prod      = '0;
      out_ready = 1'b0;
      wrap_b    = (136'd1 << 129) - 136'd4;
      sat_b     = (136'd1 << 129) - 136'd1;
`ifdef ACC_SAT_EN
      exp_b     = sat_b;
`else
      exp_b     = wrap_b;
`endif

      // reset state
      step();
      step();
      chk_flags("rst", 1'b0, 1'b0, 1'b0);
      chk("rst_acc", acc_out_a, 136'h0);
      chk("rst_ovf", {135'b0, ovf_a}, 136'h0);
      rst_n = 1'b1;
      step();
      chk_flags("idle", 1'b0, 1'b0, 1'b0);

      // basic sum, minimum latency
      start = 1'b1;
      step();
      start    = 1'b0;
      chk_flags("acc_entry", 1'b1, 1'b0, 1'b1);
      in_valid = 1'b1;
      prod     = 128'h1221;
      step();
      step();
      step();
      chk_flags("acc_three", 1'b1, 1'b0, 1'b1);
      step();
      in_valid = 1'b0;
      chk_flags("basic_done", 1'b0, 1'b1, 1'b1);
      chk("basic_acc", acc_out_a, 136'h4884);
      chk("basic_ovf", {135'b0, ovf_a}, 136'h0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk_flags("basic_retire", 1'b0, 1'b0, 1'b0);

      // bubbles with garbage on prod, then backpressure
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = (i % 2 == 0);
         prod     = in_valid ? 128'h1221 : 128'hFFFF_0000;
         step();
      end
      chk_flags("bub_done", 1'b0, 1'b1, 1'b1);
      chk("bub_acc", acc_out_a, 136'h4884);
      in_valid = 1'b1;
      prod     = 128'h7777;
      for (int i = 0; i < 3; i++) begin
         start = (i == 1);
         step();
         chk("hold_acc", acc_out_a, 136'h4884);
         chk_flags("hold", 1'b0, 1'b1, 1'b1);
      end
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk_flags("bub_retire", 1'b0, 1'b0, 1'b0);
      chk("bub_acc_idle", acc_out_a, 136'h4884);

      // overflow: four products of 2^128-1
      start = 1'b1;
      step();
      start    = 1'b0;
      in_valid = 1'b1;
      prod     = '1;
      for (int i = 0; i < 4; i++) step();
      in_valid = 1'b0;
      chk("ovf_b_valid", {135'b0, out_valid_b}, 136'h1);
      chk("ovf_b_acc", {7'b0, acc_out_b}, exp_b);
      chk("ovf_b_flag", {135'b0, ovf_b}, 136'h1);
      chk("ovf_a_acc", acc_out_a, (136'd1 << 130) - 136'd4);
      chk("ovf_a_flag", {135'b0, ovf_a}, 136'h0);

      // back-to-back: retire and restart on the same edge
      out_ready = 1'b1;
      start     = 1'b1;
      step();
      out_ready = 1'b0;
      start     = 1'b0;
      chk_flags("b2b_acc", 1'b1, 1'b0, 1'b1);
      chk("b2b_clr_ovf", {135'b0, ovf_b}, 136'h0);
      chk("b2b_clr_acc", {7'b0, acc_out_b}, 136'h0);
      in_valid = 1'b1;
      prod     = 128'h1;
      for (int i = 0; i < 4; i++) step();
      in_valid = 1'b0;
      chk_flags("b2b_done", 1'b0, 1'b1, 1'b1);
      chk("b2b_acc_a", acc_out_a, 136'h4);
      chk("b2b_acc_b", {7'b0, acc_out_b}, 136'h4);
      chk("b2b_ovf_b", {135'b0, ovf_b}, 136'h0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk_flags("b2b_retire", 1'b0, 1'b0, 1'b0);

      // reset mid-operation
      start = 1'b1;
      step();
      start    = 1'b0;
      in_valid = 1'b1;
      prod     = 128'h1221;
      step();
      step();
      chk("mid_acc", acc_out_a, 136'h2442);
      rst_n = 1'b0;
      #1;
      chk_flags("mid_rst", 1'b0, 1'b0, 1'b0);
      chk("mid_rst_acc", acc_out_a, 136'h0);
      chk("mid_rst_ovf_b", {135'b0, ovf_b}, 136'h0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step();
      chk_flags("post_rst", 1'b0, 1'b0, 1'b0);
      chk("post_rst_acc", acc_out_a, 136'h0);
      in_valid = 1'b0;
      start    = 1'b1;
      step();
      start    = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) step();
      in_valid = 1'b0;
      chk_flags("fresh_done", 1'b0, 1'b1, 1'b1);
      chk("fresh_acc", acc_out_a, 136'h4884);
      chk("fresh_ovf", {135'b0, ovf_a}, 136'h0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk_flags("fresh_retire", 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mult_acc128.md
# mult_acc128

Dot-product accumulator sitting directly downstream of the 64x64 unsigned multiplier. It consumes the multiplier's 128-bit products one per handshake and sums LEN consecutive products into a wide accumulator. It presents the finished sum on a registered valid/ready output port. It adds the sequencing, backpressure and overflow handling that the combinational multiplier lacks.

## Interface
- PW, 128, product width; must match multiplier output.
- AW, 136, accumulator/result width; AW >= PW required.
- LEN, 4, products per dot product; LEN >= 1.
- CW, $clog2(LEN)+1, counter width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a new dot product.
- in_valid  in  1  product valid.
- in_ready  out  1  accumulator accepts product.
- prod  in  PW  unsigned product from multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- acc_out  out  AW  accumulated sum, registered.
- ovf  out  1  sticky overflow for the current or last dot product.
- busy  out  1  high in ACC or DONE.

## Operation
- States: IDLE, ACC, DONE; state register is the only source of in_ready, out_valid and busy.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> acc<=0, cnt<=0, ovf<=0, go ACC.
- ACC:
  - in_ready=1.
  - Each in_valid&in_ready cycle: acc<=acc+zero-extended prod (AW bits), cnt<=cnt+1.
  - Handshake with cnt==LEN-1 -> go DONE.
  - in_valid low cycles are bubbles: no change.
  - start ignored.
- DONE:
  - out_valid=1, in_ready=0.
  - acc_out and ovf held stable until out_ready.
  - out_ready=1 & start=0 -> IDLE.
  - out_ready=1 & start=1 -> result retired and new dot product begun same edge (acc/cnt/ovf cleared, go ACC).
  - start without out_ready ignored.
- Arithmetic: unsigned; sum computed at AW+1 bits; bit AW is carry. Carry=1 sets ovf (sticky until next start).
- acc_out is the accumulator register itself; it is meaningful only while out_valid=1.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, acc_out=0, cnt=0, ovf=0, out_valid=0, in_ready=0, busy=0.
- Reset mid-operation aborts immediately. No partial result is emitted.
- Minimum latency: start at edge 0 -> ACC from cycle 1; products accepted cycles 1..LEN; out_valid high from cycle LEN+1.
- Throughput: one product per cycle in ACC.
- Back-to-back dot products need no idle cycle when start coincides with out_ready in DONE.
- prod is sampled only on in_valid&in_ready; value ignored otherwise.

## Configuration
- ACC_SAT_EN defined: on carry, acc clamps to all ones (2^AW-1) and stays clamped for the rest of the dot product; ovf=1.
- ACC_SAT_EN undefined: acc wraps modulo 2^AW; ovf=1 still reported.

## Test plan
- Basic sum: LEN=4, start, four prods of 64'h11*64'h111=128'h1221 on consecutive cycles -> out_valid at cycle 5, acc_out=136'h4884, ovf=0.
- Bubbles and backpressure: same products with in_valid low every other cycle, out_ready held low 3 cycles -> acc_out=136'h4884 held stable, in_ready=0 in DONE, return to IDLE on out_ready.
- Overflow wrap (AW=129, no ACC_SAT_EN): four prods of 2^128-1 -> acc_out=2^129-4, ovf=1.
- Overflow saturate (AW=129, ACC_SAT_EN): same stimulus -> acc_out=2^129-1, ovf=1.
- Back-to-back: start asserted with out_ready in DONE, next four prods of 128'h1 -> first result retired, second acc_out=136'h4, no IDLE cycle.
- Reset mid-operation: rst_n low after two products -> all outputs zero immediately. After release with no start: out_valid stays 0. A fresh start yields a correct sum.
